// File: rtl/b11_seq_pkg.sv
// b11_seq_pkg: shared types and MISR step for the b11 stimulus sequencer
package b11_seq_pkg;
  typedef struct packed {
    logic       obs;
    logic       stbi;
    logic [5:0] x_in;
  } opcode_t;
  typedef enum logic [1:0] {IDLE, FETCH, RUN, HOLD} state_t;
  localparam logic [15:0] MISR_POLY = 16'h100B;
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [5:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {10'h000, d};
  endfunction
endpackage

// File: rtl/b11_seq_ram.sv
// b11_seq_ram: DEPTH x 8 opcode memory, one write port, registered read port
//   clk_i, we_i/waddr_i/wdata_i write; re_i/raddr_i read, rdata_o valid the cycle after re_i
module b11_seq_ram
  import b11_seq_pkg::*;
#(
  parameter int DEPTH = 151,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  opcode_t       wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output opcode_t       rdata_o
);
  opcode_t mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    // write-first: a load and a read of the same address in one cycle return the new opcode
    if (re_i) rdata_o <= (we_i && waddr_i == raddr_i) ? wdata_i : mem[raddr_i];
  end
endmodule

// File: rtl/b11_stim_sequencer.sv
// b11_stim_sequencer: steps a loaded opcode program onto b11 {obs,stbi,x_in}
//   clock_i/reset_i (async, active-high); ld_* program load, ld_err_o rejected load/start;
//   start_i/len_i/loop_i/pause_i/abort_i run control; busy_o, done_o, pc_o status;
//   obs_o/stbi_o/x_in_o to b11, x_out_i from b11, sig_o x_out MISR
//   Define B11_SEQ_SIG_EN to build the MISR; otherwise sig_o is 0.
module b11_stim_sequencer
  import b11_seq_pkg::*;
#(
  parameter int DEPTH = 151,
  parameter int AW    = 8
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [7:0]    ld_data_i,
  output logic          ld_err_o,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic          loop_i,
  input  logic          pause_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] pc_o,
  output logic          obs_o,
  output logic          stbi_o,
  output logic [5:0]    x_in_o,
  input  logic [5:0]    x_out_i,
  output logic [15:0]   sig_o
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  state_t        state_q;
  opcode_t       op_q, rdata;
  logic [AW-1:0] pc_q, nxt_q, last_q, nxt_inc, raddr;
  logic          loop_q, done_q, err_q, busy, len_ok, start_ok, ld_bad, we, re;
  assign busy     = state_q != IDLE;
  assign len_ok   = len_i != '0 && len_i <= DEPTH_W;
  assign start_ok = state_q == IDLE && start_i && !abort_i && len_ok;
  assign ld_bad   = ld_we_i && (busy || {1'b0, ld_addr_i} >= DEPTH_W);
  assign we       = ld_we_i && !ld_bad;
  // nxt_q is the address whose opcode sits in the RAM read register, one ahead of pc
  assign nxt_inc  = nxt_q == last_q ? '0 : nxt_q + 1'b1;
  assign re       = !((state_q == RUN || state_q == HOLD) && pause_i);
  assign raddr    = state_q == IDLE ? '0 : nxt_inc;
  b11_seq_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clock_i),
    .we_i    (we),
    .waddr_i (ld_addr_i),
    .wdata_i (opcode_t'(ld_data_i)),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      pc_q    <= '0;
      nxt_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q  <= ld_bad || (state_q == IDLE && start_i && !abort_i && !len_ok);
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        op_q    <= '0;
        pc_q    <= '0;
        nxt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            nxt_q <= '0;
            if (start_ok) begin
              state_q <= FETCH;
              last_q  <= AW'(len_i - 1'b1);
              loop_q  <= loop_i;
            end
          end
          FETCH: begin
            state_q <= RUN;
            op_q    <= rdata;
            pc_q    <= '0;
            nxt_q   <= nxt_inc;
            done_q  <= !loop_q && last_q == '0;
          end
          default: begin
            if (pause_i) state_q <= HOLD;
            else if (pc_q == last_q && !loop_q) begin
              state_q <= IDLE;
              op_q    <= '0;
              pc_q    <= '0;
              nxt_q   <= '0;
            end else begin
              state_q <= RUN;
              op_q    <= rdata;
              pc_q    <= nxt_q;
              nxt_q   <= nxt_inc;
              // done rides along with the last opcode of a one-shot run
              done_q  <= !loop_q && nxt_q == last_q;
            end
          end
        endcase
      end
    end
  end
`ifdef B11_SEQ_SIG_EN
  logic [15:0] sig_q;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) sig_q <= '0;
    else if (start_ok) sig_q <= '0;
    else if (state_q == RUN) sig_q <= misr_next(sig_q, x_out_i);
  end
  assign sig_o = sig_q;
`else
  logic unused_x_out;
  assign unused_x_out = ^x_out_i;
  assign sig_o        = '0;
`endif
  assign ld_err_o = err_q;
  assign busy_o   = busy;
  assign done_o   = done_q;
  assign pc_o     = pc_q;
  assign obs_o    = op_q.obs;
  assign stbi_o   = op_q.stbi;
  assign x_in_o   = op_q.x_in;
endmodule
